// File: rtl/quiz_buzzer_arbiter.sv
// quiz_buzzer_arbiter
//   N-player quiz buzzer arbiter. Arms a round, latches the first eligible player to buzz (lowest
//   index wins ties), times the answer window, applies the judge's verdict to per-player scores and
//   re-opens the round to the remaining players after a wrong or timed-out answer.
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 pulse: arm a new round from IDLE
//   i_abort                 pulse: end the round now, no scoring
//   i_clear_scores          pulse: zero all scores
//   i_buzz[N_PLAYERS]       debounced player buttons (level)
//   i_judge_yes/i_judge_no  pulses: verdict on the current answer
//   o_state                 0 IDLE, 1 ARMED, 2 ANSWER
//   o_winner                one-hot answering player (0 if none)
//   o_locked_out            players excluded for the rest of the round
//   o_time_left             answer ticks remaining (0 outside ANSWER)
//   o_alarm_en              beeper enable
//   o_scores                player i score at [i*SCORE_W +: SCORE_W]
`timescale 1ns/1ps
module quiz_buzzer_arbiter #(
   parameter int unsigned N_PLAYERS    = 4,
   parameter int unsigned SCORE_W      = 8,
   parameter int unsigned TICK_DIV     = 50000000,
   parameter int unsigned ANSWER_TICKS = 8,
   parameter int unsigned ALARM_TICKS  = 2,
   parameter int unsigned PENALTY      = 1,
   parameter int unsigned FALSE_START  = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   input  logic                           i_abort,
   input  logic                           i_clear_scores,
   input  logic [N_PLAYERS-1:0]           i_buzz,
   input  logic                           i_judge_yes,
   input  logic                           i_judge_no,
   output logic [1:0]                     o_state,
   output logic [N_PLAYERS-1:0]           o_winner,
   output logic [N_PLAYERS-1:0]           o_locked_out,
   output logic [7:0]                     o_time_left,
   output logic                           o_alarm_en,
   output logic [N_PLAYERS*SCORE_W-1:0]   o_scores
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TickW-1:0]   TickLast  = TickW'(TICK_DIV - 1);
   localparam logic [7:0]         TicksInit = 8'(ANSWER_TICKS);
   localparam logic [7:0]         AlarmOff  = 8'(ANSWER_TICKS - ALARM_TICKS);
   localparam logic [SCORE_W-1:0] PenaltyS  = SCORE_W'(PENALTY);
   localparam logic [SCORE_W-1:0] OneS      = SCORE_W'(1);
   localparam logic [N_PLAYERS-1:0] OneP    = N_PLAYERS'(1);

   typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StAnswer = 2'd2} state_e;

   state_e                              r_state, w_state_nxt;
   logic [N_PLAYERS-1:0]                r_buzz_q;
   logic [N_PLAYERS-1:0]                r_winner, w_winner_nxt;
   logic [N_PLAYERS-1:0]                r_locked_out, w_locked_out_nxt;
   // False starts recorded in IDLE; they survive the next start and are consumed by it.
   logic [N_PLAYERS-1:0]                r_false, w_false_nxt;
   logic [7:0]                          r_time_left, w_time_left_nxt;
   logic [TickW-1:0]                    r_tick, w_tick_nxt;
   logic                                r_alarm, w_alarm_nxt;
   logic [N_PLAYERS-1:0][SCORE_W-1:0]   r_scores, w_scores_nxt;

   logic [N_PLAYERS-1:0] w_press, w_eligible, w_pick, w_fs_press;
   logic                 w_wrap, w_timeout, w_judge_ok, w_judge_bad, w_right, w_wrong;
   logic                 w_all_locked;

   always_comb begin
      w_press     = i_buzz & ~r_buzz_q;
      w_fs_press  = (FALSE_START != 0) ? w_press : '0;
      w_eligible  = w_press & ~r_locked_out;
      // Isolate lowest set bit: fixed priority, lowest index wins.
      w_pick      = w_eligible & (~w_eligible + OneP);
      w_wrap      = (r_tick == TickLast);
      w_timeout   = w_wrap && (r_time_left == 8'd1);
      w_judge_ok  = i_judge_yes & ~i_judge_no;
      w_judge_bad = i_judge_no & ~i_judge_yes;
      w_right     = (r_state == StAnswer) && w_judge_ok;
      // A simultaneous yes+no is no verdict, so a coinciding timeout still applies.
      w_wrong     = (r_state == StAnswer) && !w_judge_ok && (w_judge_bad || w_timeout);
      w_all_locked = &(r_locked_out | r_winner);
   end

   // State register plus datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_buzz_q     <= '0;
         r_winner     <= '0;
         r_locked_out <= '0;
         r_false      <= '0;
         r_time_left  <= '0;
         r_tick       <= '0;
         r_alarm      <= 1'b0;
         r_scores     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_buzz_q     <= i_buzz;
         r_winner     <= w_winner_nxt;
         r_locked_out <= w_locked_out_nxt;
         r_false      <= w_false_nxt;
         r_time_left  <= w_time_left_nxt;
         r_tick       <= w_tick_nxt;
         r_alarm      <= w_alarm_nxt;
         r_scores     <= w_scores_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = StIdle;
      end else begin
         unique case (r_state)
            StIdle:   if (i_start) w_state_nxt = StArmed;
            StArmed:  if (|w_eligible) w_state_nxt = StAnswer;
            StAnswer: begin
               if (w_right)      w_state_nxt = StIdle;
               else if (w_wrong) w_state_nxt = w_all_locked ? StIdle : StArmed;
            end
            default:  w_state_nxt = StIdle;
         endcase
      end
   end

   // Datapath next values.
   always_comb begin
      w_winner_nxt     = r_winner;
      w_locked_out_nxt = r_locked_out;
      w_false_nxt      = r_false;
      w_time_left_nxt  = r_time_left;
      w_tick_nxt       = r_tick;
      w_alarm_nxt      = r_alarm;
      if (i_abort) begin
         w_winner_nxt    = '0;
         w_time_left_nxt = '0;
         w_tick_nxt      = '0;
         w_alarm_nxt     = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  w_locked_out_nxt = r_false | w_fs_press;
                  w_false_nxt      = '0;
               end else begin
                  w_locked_out_nxt = r_locked_out | w_fs_press;
                  w_false_nxt      = r_false | w_fs_press;
               end
            end
            StArmed: begin
               if (|w_eligible) begin
                  w_winner_nxt    = w_pick;
                  w_time_left_nxt = TicksInit;
                  w_tick_nxt      = '0;
                  w_alarm_nxt     = (ALARM_TICKS != 0);
               end
            end
            StAnswer: begin
               if (w_right || w_wrong) begin
                  w_winner_nxt    = '0;
                  w_time_left_nxt = '0;
                  w_tick_nxt      = '0;
                  w_alarm_nxt     = 1'b0;
                  if (w_wrong) w_locked_out_nxt = r_locked_out | r_winner;
               end else if (w_wrap) begin
                  w_tick_nxt      = '0;
                  w_time_left_nxt = r_time_left - 8'd1;
                  if ((r_time_left - 8'd1) == AlarmOff) w_alarm_nxt = 1'b0;
               end else begin
                  w_tick_nxt = r_tick + TickW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Scores: clear beats the verdict; abort suppresses scoring.
   always_comb begin
      for (int i = 0; i < N_PLAYERS; i++) begin
         w_scores_nxt[i] = r_scores[i];
         if (i_clear_scores) begin
            w_scores_nxt[i] = '0;
         end else if (!i_abort && r_winner[i]) begin
            if (w_right) begin
               if (r_scores[i] != '1) w_scores_nxt[i] = r_scores[i] + OneS;
            end else if (w_wrong) begin
               w_scores_nxt[i] = (r_scores[i] < PenaltyS) ? '0 : r_scores[i] - PenaltyS;
            end
         end
      end
   end

   // Outputs.
   always_comb begin
      o_state      = r_state;
      o_winner     = r_winner;
      o_locked_out = r_locked_out;
      o_time_left  = r_time_left;
      o_alarm_en   = r_alarm;
      o_scores     = r_scores;
   end

endmodule

// File: tb/tb_quiz_buzzer_arbiter.sv
`timescale 1ns/1ps
module tb_quiz_buzzer_arbiter;

   localparam int NP = 4;
   localparam int SW = 8;
   localparam int TD = 10;
   localparam int AT = 8;
   localparam int LT = 2;

   logic            clk = 1'b0;
   logic            rst, start, abort_p, clr, jy, jn;
   logic [NP-1:0]   buzz;
   logic [1:0]      state;
   logic [NP-1:0]   winner, locked;
   logic [7:0]      time_left;
   logic            alarm;
   logic [NP*SW-1:0] scores;

   int checks = 0;
   int errors = 0;

   // Reference model: round described in elapsed answer cycles and plain integers.
   int         m_state, m_win, m_el;
   logic [3:0] m_lock, m_false, m_bq;
   int         m_score [NP];

   quiz_buzzer_arbiter #(
      .N_PLAYERS(NP), .SCORE_W(SW), .TICK_DIV(TD), .ANSWER_TICKS(AT),
      .ALARM_TICKS(LT), .PENALTY(1), .FALSE_START(1)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_p),
      .i_clear_scores(clr), .i_buzz(buzz), .i_judge_yes(jy), .i_judge_no(jn),
      .o_state(state), .o_winner(winner), .o_locked_out(locked),
      .o_time_left(time_left), .o_alarm_en(alarm), .o_scores(scores)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_win = -1; m_el = 0;
      m_lock = '0; m_false = '0; m_bq = '0;
      for (int i = 0; i < NP; i++) m_score[i] = 0;
   endtask

   task automatic model_step(input bit st, input bit ab, input bit cl, input logic [3:0] bz,
                             input bit y, input bit n);
      logic [3:0] press;
      logic [3:0] elig;
      bit ok, bad, tmo;
      press = bz & ~m_bq;
      ok    = y && !n;
      bad   = n && !y;
      tmo   = (m_el + 1 >= AT * TD);
      if (ab) begin
         m_state = 0; m_win = -1; m_el = 0;
      end else if (m_state == 0) begin
         if (st) begin
            m_lock = m_false | press; m_false = '0; m_state = 1;
         end else begin
            m_lock |= press; m_false |= press;
         end
      end else if (m_state == 1) begin
         elig = press & ~m_lock;
         for (int i = NP - 1; i >= 0; i--) if (elig[i]) m_win = i;
         if (elig != 0) begin
            m_state = 2; m_el = 0;
         end
      end else begin
         if (ok) begin
            if (m_score[m_win] < 255) m_score[m_win]++;
            m_win = -1; m_state = 0; m_el = 0;
         end else if (bad || tmo) begin
            if (m_score[m_win] > 0) m_score[m_win]--;
            m_lock[m_win] = 1'b1;
            m_win = -1; m_el = 0;
            m_state = (m_lock == 4'hF) ? 0 : 1;
         end else begin
            m_el++;
         end
      end
      if (cl) for (int i = 0; i < NP; i++) m_score[i] = 0;
      m_bq = bz;
   endtask

   task automatic check_all();
      logic [31:0] exp_sc;
      chk("state", 32'(state), 32'(m_state));
      chk("winner", 32'(winner), (m_win < 0) ? 32'd0 : (32'd1 << m_win));
      chk("locked_out", 32'(locked), 32'(m_lock));
      chk("time_left", 32'(time_left), (m_state == 2) ? 32'(AT - m_el / TD) : 32'd0);
      chk("alarm_en", 32'(alarm), 32'((m_state == 2) && (m_el < LT * TD)));
      exp_sc = '0;
      for (int i = 0; i < NP; i++) exp_sc[i*8 +: 8] = 8'(m_score[i]);
      chk("scores", scores, exp_sc);
   endtask

   task automatic step(input bit st, input bit ab, input bit cl, input logic [3:0] bz,
                       input bit y, input bit n);
      start = st; abort_p = ab; clr = cl; buzz = bz; jy = y; jn = n;
      @(posedge clk);
      model_step(st, ab, cl, bz, y, n);
      #1;
      check_all();
      start = 0; abort_p = 0; clr = 0; jy = 0; jn = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 0; abort_p = 0; clr = 0; jy = 0; jn = 0; buzz = '0;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
      check_all();
   endtask

   task automatic wait_n(input int n, input logic [3:0] bz);
      for (int i = 0; i < n; i++) step(0, 0, 0, bz, 0, 0);
   endtask

   logic [3:0] rbz;

   initial begin
      rst = 1'b1; start = 0; abort_p = 0; clr = 0; jy = 0; jn = 0; buzz = '0;
      model_reset();
      do_reset();
      chk("reset_scores", scores, 32'd0);

      // Winner latch, answer timer and alarm window.
      step(1, 0, 0, 4'b0000, 0, 0);
      step(0, 0, 0, 4'b0100, 0, 0);
      chk("first_winner", 32'(winner), 32'h4);
      chk("first_time_left", 32'(time_left), 32'd8);
      chk("first_alarm", 32'(alarm), 32'd1);
      wait_n(19, 4'b0100);
      chk("alarm_before_20", 32'(alarm), 32'd1);
      wait_n(1, 4'b0100);
      chk("alarm_after_20", 32'(alarm), 32'd0);
      chk("time_left_after_20", 32'(time_left), 32'd6);
      step(0, 0, 0, 4'b0000, 1, 0);

      // Tie: lowest index wins.
      step(1, 0, 0, 4'b0000, 0, 0);
      step(0, 0, 0, 4'b1010, 0, 0);
      chk("tie_winner", 32'(winner), 32'h2);
      step(0, 0, 0, 4'b0000, 1, 0);
      chk("yes_score1", 32'(scores[15:8]), 32'd1);

      // Wrong answer with score floor, then lockout and timeouts.
      step(1, 0, 0, 4'b0000, 0, 0);
      step(0, 0, 0, 4'b0001, 0, 0);
      step(0, 0, 0, 4'b0001, 0, 1);
      chk("no_locked", 32'(locked), 32'h1);
      chk("no_state", 32'(state), 32'd1);
      step(0, 0, 0, 4'b0000, 0, 0);
      step(0, 0, 0, 4'b0001, 0, 0);
      chk("locked_press_ignored", 32'(winner), 32'd0);
      step(0, 0, 0, 4'b1000, 0, 0);
      wait_n(79, 4'b1000);
      chk("before_timeout", 32'(time_left), 32'd1);
      wait_n(1, 4'b1000);
      chk("timeout_locked", 32'(locked), 32'h9);
      step(0, 0, 0, 4'b0100, 0, 0);
      step(0, 0, 0, 4'b0100, 0, 1);
      step(0, 0, 0, 4'b0110, 0, 0);
      step(0, 0, 0, 4'b0110, 0, 1);
      chk("all_locked_idle", 32'(state), 32'd0);

      // False start survives the next start.
      do_reset();
      step(0, 0, 0, 4'b0010, 0, 0);
      chk("false_start_lock", 32'(locked), 32'h2);
      step(1, 0, 0, 4'b0000, 0, 0);
      step(0, 0, 0, 4'b0010, 0, 0);
      chk("false_start_no_win", 32'(winner), 32'd0);
      step(0, 0, 0, 4'b0011, 0, 0);
      chk("after_false_start", 32'(winner), 32'h1);
      step(0, 1, 0, 4'b0000, 0, 0);

      // Saturation at 255.
      for (int r = 0; r < 256; r++) begin
         step(1, 0, 0, 4'b0000, 0, 0);
         step(0, 0, 0, 4'b0100, 0, 0);
         step(0, 0, 0, 4'b0000, 1, 0);
      end
      chk("saturate", 32'(scores[23:16]), 32'd255);

      // Clear beats a same-cycle verdict; reset mid-answer.
      step(1, 0, 0, 4'b0000, 0, 0);
      step(0, 0, 0, 4'b0100, 0, 0);
      step(0, 0, 1, 4'b0000, 1, 0);
      chk("clear_wins", scores, 32'd0);
      step(1, 0, 0, 4'b0000, 0, 0);
      step(0, 0, 0, 4'b0001, 0, 0);
      do_reset();
      chk("rst_mid_answer", {22'd0, state, winner, time_left}, 32'd0);

      // Randomized traffic against the model.
      rbz = '0;
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            rbz = '0;
         end else begin
            if ($urandom_range(0, 3) == 0) rbz[$urandom_range(0, 3)] ^= 1'b1;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 79) == 0, rbz,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
